spatz_vrf_wbuf: RTL and testbench
=================================

// Module: spatz_vrf_wbuf
// PURPOSE
// - Write-back buffer between one result producer (VFU, VLSU or VSLDU) and its VRF write port.
// - The VRF arbitrates banks per cycle and may withhold wvalid.
// - Absorbs that backpressure in a small in-order FIFO, so the producer sees a plain valid/ready handshake.
// - The producer does not need to hold its result until the bank grant arrives.
// - One instance per VRF write port.
// PARAMETERS
// - Depth    4    FIFO entries, >=2, any integer (need not be a power of two).
// PORTS
// - clk_i        in   1                       clock
// - rst_i        in   1                       synchronous reset, active-high
// - in_valid_i   in   1                       producer write request valid
// - in_ready_o   out  1                       buffer can accept a request
// - in_waddr_i   in   $bits(vreg_addr_t)      vreg/bank address, spatz_pkg::vreg_addr_t
// - in_wdata_i   in   $bits(vreg_data_t)      write data
// - in_wbe_i     in   $bits(vreg_be_t)        byte enables
// - waddr_o      out  $bits(vreg_addr_t)      to VRF waddr_i[port]
// - wdata_o      out  $bits(vreg_data_t)      to VRF wdata_i[port]
// - wbe_o        out  $bits(vreg_be_t)        to VRF wbe_i[port]
// - we_o         out  1                       to VRF we_i[port]
// - wvalid_i     in   1                       from VRF wvalid_o[port]; write committed this cycle
// - empty_o      out  1                       no entries held; producer may retire
// - count_o      out  $clog2(Depth+1)         current occupancy
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge):
//   - count, read and write pointers <= 0.
//   - we_o=0, empty_o=1, in_ready_o=1, count_o=0.
//   - Entries held at reset are dropped, never written to the VRF.
// - Push: in_valid_i && in_ready_o at an edge stores {waddr,wdata,wbe} at wptr.
//   - wptr advances and wraps from Depth-1 to 0.
// - in_ready_o = (count != Depth).
//   - Registered state only; no combinational path from wvalid_i.
//   - When full, a same-cycle pop does not enable a push.
// - Head presentation: we_o = (count != 0); waddr_o/wdata_o/wbe_o = entry[rptr].
//   - Outputs are '0 when empty.
// - Pop: we_o && wvalid_i at an edge. rptr advances with wrap; the entry is retired.
// - Handshake rules:
//   - Head fields stay stable while we_o=1 and wvalid_i=0.
//   - wvalid_i while we_o=0 is ignored.
// - Simultaneous push and pop: count unchanged, both pointers advance.
// - Ordering is strictly FIFO. No coalescing, and no reordering across banks.
// - Latency without bypass: an accepted request reaches we_o the next cycle.
//   - Commit occurs on the first cycle after that with wvalid_i=1.
// - count_o = count; empty_o = (count == 0).
// - Overflow and underflow are impossible by construction. Assert both in simulation.
// CONFIGURATION
// - SPATZ_VRF_WBUF_BYPASS_EN defined:
//   - When count==0 and in_valid_i=1, input fields drive the outputs combinationally and we_o=1.
//   - If wvalid_i=1 that cycle, the request commits without being stored. No push, count stays 0.
//   - Otherwise it is pushed normally.
//   - in_ready_o is unchanged.
//   - empty_o remains count-based.
// - SPATZ_VRF_WBUF_BYPASS_EN undefined:
//   - Outputs come from storage only; minimum latency is 1 cycle.
// TESTING
// - Reset, then idle:
//   - Required: we_o=0, in_ready_o=1, empty_o=1, count_o=0.
// - Push 0xA1,0xA2,0xA3,0xA4 back-to-back with wvalid_i=0:
//   - count_o 1..4, in_ready_o=0 after the 4th push.
//   - 5th request held; head stays 0xA1.
// - Full FIFO, raise wvalid_i for 4 cycles:
//   - Commits in order A1,A2,A3,A4; we_o=0 after; empty_o=1.
// - Continuous push, wvalid_i toggling 1,0,1,0 for 12 requests:
//   - All 12 commit in order with no loss or duplication.
//   - Pointers wrap at least twice.
// - rst_i pulse with 3 entries held:
//   - Next cycle count_o=0, we_o=0.
//   - None of the 3 entries appears on the outputs afterwards.
// - Bypass on, empty FIFO, in_valid_i=1, wvalid_i=1, data 0x55:
//   - we_o=1 and wdata_o=0x55 the same cycle; count_o stays 0.
// - Bypass off, same stimulus:
//   - we_o=1 one cycle later; count_o=1 until the commit.

Source files
------------

// File: rtl/spatz_vrf_wbuf.sv
// spatz_vrf_wbuf: in-order write-back buffer in front of one VRF write port.
// Absorbs VRF bank-arbitration backpressure (wvalid_i withheld) so the
// producer only sees a valid/ready handshake.
// AddrWidth/DataWidth/BeWidth correspond to spatz_pkg::vreg_addr_t,
// vreg_data_t and vreg_be_t.
// Optional feature macro: SPATZ_VRF_WBUF_BYPASS_EN (empty-FIFO combinational
// bypass). Default build (macro undefined): outputs come from storage only.
module spatz_vrf_wbuf #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [AddrWidth-1:0]         in_waddr_i,
  input  logic [DataWidth-1:0]         in_wdata_i,
  input  logic [BeWidth-1:0]           in_wbe_i,
  output logic [AddrWidth-1:0]         waddr_o,
  output logic [DataWidth-1:0]         wdata_o,
  output logic [BeWidth-1:0]           wbe_o,
  output logic                         we_o,
  input  logic                         wvalid_i,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr   = PtrWidth'(Depth - 1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [BeWidth-1:0]   be;
  } entry_t;

  entry_t mem_q [Depth];

  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  entry_t in_entry;
  entry_t head;
  logic   full, empty;
  logic   push, pop;
  logic   bypass_hit, bypass_commit;

  assign in_entry = {in_waddr_i, in_wdata_i, in_wbe_i};

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // Ready depends only on registered occupancy: a pop in the same cycle
  // never opens a slot for a push while full.
  assign in_ready_o = !full;
  assign empty_o    = empty;
  assign count_o    = count_q;

`ifdef SPATZ_VRF_WBUF_BYPASS_EN
  // An empty buffer forwards the incoming request straight to the port; if
  // the VRF takes it this cycle it is never stored.
  assign bypass_hit    = empty && in_valid_i;
  assign bypass_commit = bypass_hit && wvalid_i;
`else
  assign bypass_hit    = 1'b0;
  assign bypass_commit = 1'b0;
`endif

  assign push = in_valid_i && !full && !bypass_commit;
  assign pop  = !empty && wvalid_i;

  // Head presentation: stored head entry, bypassed input, or all zeros.
  always_comb begin
    head = '0;
    we_o = 1'b0;
    if (!empty) begin
      head = mem_q[rptr_q];
      we_o = 1'b1;
    end else if (bypass_hit) begin
      head = in_entry;
      we_o = 1'b1;
    end
  end

  assign waddr_o = head.addr;
  assign wdata_o = head.data;
  assign wbe_o   = head.be;

  // Pointer and occupancy next-state; pointers wrap at Depth-1 so any
  // Depth works, not only powers of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; entries held at reset are simply forgotten.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

  // Overflow/underflow cannot happen by construction; catch regressions.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count_q <= FullCount);
    end
  end

endmodule

// File: tb/tb_spatz_vrf_wbuf.sv
// Testbench for spatz_vrf_wbuf: table-driven directed rows plus hand-written
// sequences, with a queue scoreboard checked every cycle on the falling edge.
module tb_spatz_vrf_wbuf;

  localparam int Depth = 4;
`ifdef SPATZ_VRF_WBUF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_waddr_i;
  logic [63:0] in_wdata_i;
  logic [7:0]  in_wbe_i;
  logic [7:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [7:0]  wbe_o;
  logic        we_o;
  logic        wvalid_i;
  logic        empty_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  spatz_vrf_wbuf #(.Depth(Depth), .AddrWidth(8), .DataWidth(64), .BeWidth(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_waddr_i (in_waddr_i),
    .in_wdata_i (in_wdata_i),
    .in_wbe_i   (in_wbe_i),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .wbe_o      (wbe_o),
    .we_o       (we_o),
    .wvalid_i   (wvalid_i),
    .empty_o    (empty_o),
    .count_o    (count_o)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } item_t;

  typedef struct {
    bit         in_valid;
    bit         wvalid;
    logic [7:0] id;
    bit         exp_we;
    bit         exp_ready;
    bit         exp_empty;
    logic [2:0] exp_count;
    logic [7:0] exp_head;   // 0 means outputs must be all zero
  } vec_t;

  item_t sb[$];
  int    checks  = 0;
  int    errors  = 0;
  int    commits = 0;

  function automatic item_t mk(input logic [7:0] id);
    item_t it;
    it.addr = id ^ 8'h3C;
    it.data = 64'(id);
    it.be   = ~id;
    return it;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit wv, input logic [7:0] id);
    item_t it;
    @(posedge clk);
    #1;
    it         = mk(id);
    in_valid_i = v;
    wvalid_i   = wv;
    in_waddr_i = it.addr;
    in_wdata_i = it.data;
    in_wbe_i   = it.be;
  endtask

  // Scoreboard: compare DUT against the queue model, then apply this cycle's
  // push/commit to the model.
  always @(negedge clk) begin
    item_t cur, exp_head, got;
    int    sz;
    bit    exp_we, acc;
    if (rst_i) begin
      sb.delete();
    end else begin
      sz        = sb.size();
      cur.addr  = in_waddr_i;
      cur.data  = in_wdata_i;
      cur.be    = in_wbe_i;
      acc       = in_valid_i && (sz != Depth);
      exp_we    = (sz != 0) || (Byp && in_valid_i);
      if (sz != 0)     exp_head = sb[0];
      else if (exp_we) exp_head = cur;
      else             exp_head = '{addr: 8'h0, data: 64'h0, be: 8'h0};
      check("sb_count", 80'(count_o), 80'(sz));
      check("sb_ready", 80'(in_ready_o), 80'(sz != Depth));
      check("sb_empty", 80'(empty_o), 80'(sz == 0));
      check("sb_we", 80'(we_o), 80'(exp_we));
      check("sb_head", {waddr_o, wdata_o, wbe_o}, {exp_head.addr, exp_head.data, exp_head.be});
      if (acc) sb.push_back(cur);
      if (exp_we && wvalid_i) begin
        got = sb.pop_front();
        commits++;
        $display("commit #%0d addr=%h data=%h be=%h", commits, got.addr, got.data, got.be);
      end
    end
  end

  vec_t vecs[12];

  initial begin
    int sent, budget, base;
    bit tog;

    // Fill 4 with wvalid low, hold a 5th request, then drain 4 commits.
    vecs[0]  = '{0, 0, 8'h00, 0, 1, 1, 3'd0, 8'h00};
    vecs[1]  = '{1, 0, 8'hA1, Byp, 1, 1, 3'd0, Byp ? 8'hA1 : 8'h00};
    vecs[2]  = '{1, 0, 8'hA2, 1, 1, 0, 3'd1, 8'hA1};
    vecs[3]  = '{1, 0, 8'hA3, 1, 1, 0, 3'd2, 8'hA1};
    vecs[4]  = '{1, 0, 8'hA4, 1, 1, 0, 3'd3, 8'hA1};
    vecs[5]  = '{1, 0, 8'hA5, 1, 0, 0, 3'd4, 8'hA1};
    vecs[6]  = '{1, 0, 8'hA5, 1, 0, 0, 3'd4, 8'hA1};
    vecs[7]  = '{0, 1, 8'h00, 1, 0, 0, 3'd4, 8'hA1};
    vecs[8]  = '{0, 1, 8'h00, 1, 1, 0, 3'd3, 8'hA2};
    vecs[9]  = '{0, 1, 8'h00, 1, 1, 0, 3'd2, 8'hA3};
    vecs[10] = '{0, 1, 8'h00, 1, 1, 0, 3'd1, 8'hA4};
    vecs[11] = '{0, 0, 8'h00, 0, 1, 1, 3'd0, 8'h00};

    rst_i = 1'b1; in_valid_i = 1'b0; wvalid_i = 1'b0;
    in_waddr_i = '0; in_wdata_i = '0; in_wbe_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].in_valid, vecs[i].wvalid, vecs[i].id);
      @(negedge clk);
      check($sformatf("row%0d_we", i), 80'(we_o), 80'(vecs[i].exp_we));
      check($sformatf("row%0d_ready", i), 80'(in_ready_o), 80'(vecs[i].exp_ready));
      check($sformatf("row%0d_empty", i), 80'(empty_o), 80'(vecs[i].exp_empty));
      check($sformatf("row%0d_count", i), 80'(count_o), 80'(vecs[i].exp_count));
      check($sformatf("row%0d_wdata", i), 80'(wdata_o), 80'(vecs[i].exp_head));
    end
    check("fill_drain_commits", 80'(commits), 80'(4));

    // Continuous push, wvalid toggling: 12 requests, pointers wrap 3 times.
    base = commits; sent = 0; budget = 0; tog = 1'b1;
    while (sent < 12 && budget < 100) begin
      drive(1'b1, tog, 8'(8'h10 + sent));
      tog = ~tog;
      @(negedge clk);
      if (in_ready_o) sent++;
      budget++;
    end
    check("stream_sent", 80'(sent), 80'(12));
    budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      drive(1'b0, 1'b1, 8'h00);
      @(negedge clk);
      budget++;
    end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("stream_commits", 80'(commits - base), 80'(12));

    // Reset with 3 entries held: they must never reach the outputs.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'hB1 + i));
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("pre_rst_count", 80'(count_o), 80'(3));
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_count", 80'(count_o), 80'(0));
    check("post_rst_we", 80'(we_o), 80'(0));
    base = commits;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      @(negedge clk);
    end
    check("post_rst_no_commit", 80'(commits - base), 80'(0));

    // Empty FIFO, in_valid and wvalid together with data 0x55.
    drive(1'b1, 1'b1, 8'h55);
    @(negedge clk);
    check("byp_we0", 80'(we_o), 80'(Byp));
    check("byp_wdata0", 80'(wdata_o), Byp ? 80'h55 : 80'h0);
    check("byp_count0", 80'(count_o), 80'(0));
    drive(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    check("byp_we1", 80'(we_o), 80'(!Byp));
    check("byp_wdata1", 80'(wdata_o), Byp ? 80'h0 : 80'h55);
    check("byp_count1", 80'(count_o), 80'(!Byp));
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("byp_count2", 80'(count_o), 80'(0));
    check("byp_empty2", 80'(empty_o), 80'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
